// File: rtl/uart_frame_xcvr.sv
// uart_frame_xcvr: 8N1 UART receiver and transmitter plus a periodic report
// generator. The low nibble of the last good received byte drives active-low
// LEDs, and every PERIOD_CYCLES a 20-byte ASCII line
// "UART RX DATA: 0xHH\r\n" goes out on uart_tx.
//
// Internal request handshake (generator -> transmitter):
//   tx_start/tx_byte form a request. The transmitter takes it in any cycle
//   where tx_start=1 and tx_busy=0. tx_busy is high from the start bit
//   (the cycle after acceptance) through the end of the stop bit.
module uart_frame_xcvr #(
    parameter int BPS_NUM       = 434,
    parameter int PERIOD_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       tx_busy,
    output logic [3:0] led
);
    localparam int CW = $clog2(BPS_NUM);
    localparam int TW = $clog2(PERIOD_CYCLES);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BPS_NUM - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(BPS_NUM / 2 - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD_CYCLES - 1);
    localparam logic [127:0]  HDR        = "UART RX DATA: 0x";

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
    typedef enum logic [1:0] {G_IDLE, G_REQ, G_WAIT} gen_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic          rx_s1, rx_s2, rx_prev;
    uart_state_t   rx_state, rx_state_nx;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_fall, rx_half_tick, rx_bit_tick;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_state_nx;
    end

    // Receiver next state: a start that reads high at mid-bit is a glitch
    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_state_nx = S_START;
            S_START: if (rx_half_tick) rx_state_nx = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_bit_tick && rx_bit == 3'd7) rx_state_nx = S_STOP;
            S_STOP:  if (rx_bit_tick) rx_state_nx = S_IDLE;
            default: rx_state_nx = S_IDLE;
        endcase
    end

    // Receiver sample strobes decoded from state and bit timer
    always_comb begin
        rx_fall      = rx_prev & ~rx_s2;
        rx_half_tick = (rx_state == S_START) && (rx_cnt == HALF_LAST);
        rx_bit_tick  = (rx_state == S_DATA || rx_state == S_STOP) && (rx_cnt == BIT_LAST);
    end

    // Receiver bit timer, LSB-first shift register and result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            if (rx_state == S_IDLE || rx_half_tick || rx_bit_tick) rx_cnt <= '0;
            else                                                   rx_cnt <= rx_cnt + 1'b1;
            if (rx_half_tick) rx_bit <= '0;
            if (rx_bit_tick && rx_state == S_DATA) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_bit_tick && rx_state == S_STOP) begin
                if (rx_s2) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_frame_err <= 1'b1;
                end
            end
        end
    end

    assign led = ~rx_data[3:0];

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t   tx_state, tx_state_nx;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_tick;
    logic          tx_start;
    logic [7:0]    tx_byte;

    // Transmitter state register
    always_ff @(posedge clk) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_state_nx;
    end

    // Transmitter next state: each bit lasts exactly BPS_NUM cycles
    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            S_IDLE:  if (tx_start) tx_state_nx = S_START;
            S_START: if (tx_tick) tx_state_nx = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nx = S_STOP;
            S_STOP:  if (tx_tick) tx_state_nx = S_IDLE;
            default: tx_state_nx = S_IDLE;
        endcase
    end

    // Transmitter line level and busy flag decoded from state
    always_comb begin
        tx_tick = (tx_state != S_IDLE) && (tx_cnt == BIT_LAST);
        tx_busy = (tx_state != S_IDLE);
        case (tx_state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = tx_shift[0];
            default: uart_tx = 1'b1;
        endcase
    end

    // Transmitter bit timer and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
            else                               tx_cnt <= tx_cnt + 1'b1;
            if (tx_state == S_IDLE && tx_start) begin
                tx_shift <= tx_byte;
                tx_bit   <= '0;
            end else if (tx_tick && tx_state == S_DATA) begin
                tx_shift <= {1'b1, tx_shift[7:1]};
                tx_bit   <= tx_bit + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Report generator
    // ------------------------------------------------------------------
    gen_state_t    gen_state, gen_state_nx;
    logic [TW-1:0] timer;
    logic [4:0]    gen_idx;
    logic [7:0]    snap;
    logic          launch;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Generator state register
    always_ff @(posedge clk) begin
        if (rst) gen_state <= G_IDLE;
        else     gen_state <= gen_state_nx;
    end

    // Generator next state: one request, then wait out that byte's busy window
    always_comb begin
        gen_state_nx = gen_state;
        case (gen_state)
            G_IDLE:  if (launch) gen_state_nx = G_REQ;
            G_REQ:   if (!tx_busy) gen_state_nx = G_WAIT;
            G_WAIT:  if (!tx_busy) gen_state_nx = (gen_idx == 5'd19) ? G_IDLE : G_REQ;
            default: gen_state_nx = G_IDLE;
        endcase
    end

    // Generator request and frame byte selection
    always_comb begin
        launch   = (timer == TIMER_LAST);
        tx_start = (gen_state == G_REQ);
        case (gen_idx)
            5'd16:   tx_byte = hex_char(snap[7:4]);
            5'd17:   tx_byte = hex_char(snap[3:0]);
            5'd18:   tx_byte = 8'h0D;
            5'd19:   tx_byte = 8'h0A;
            default: tx_byte = HDR[{~gen_idx[3:0], 3'b000} +: 8];
        endcase
    end

    // Free-running interval timer, snapshot at launch, byte index advance
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            gen_idx <= '0;
            snap    <= '0;
        end else begin
            timer <= launch ? '0 : timer + 1'b1;
            if (gen_state == G_IDLE && launch) begin
                snap    <= rx_data;
                gen_idx <= '0;
            end else if (gen_state == G_WAIT && !tx_busy && gen_idx != 5'd19) begin
                gen_idx <= gen_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_xcvr.sv
// Bench for uart_frame_xcvr: drives serial bytes (directed and random) into
// uart_rx, decodes uart_tx into bytes, and compares both against a reference
// built from the frame text and the last good byte sent.
module tb_uart_frame_xcvr;
    localparam int BPS = 8;
    localparam int PER = 4000;
    localparam int W   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       tx_busy;
    logic [3:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];     // expected uart_tx bytes
    logic [W-1:0] exp_rx_q[$];  // expected rx_data at each rx_valid
    logic [7:0]   model_last = 8'h00;
    logic [3:0]   exp_led;
    int exp_valid = 0, exp_err = 0;
    int valid_cnt = 0, err_cnt = 0;
    int frames_started = 0, frames_done = 0, frame_pos = 0;
    int since_rst = 0;
    int busy_len = 0;
    bit busy_prev = 0;
    bit tx_prev = 1;
    bit mon_act = 0;
    int mon_cnt = 0;
    logic [7:0] mon_sh;

    uart_frame_xcvr #(.BPS_NUM(BPS), .PERIOD_CYCLES(PER)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
        .tx_busy(tx_busy), .led(led)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // expected report line for a given snapshot byte
    task automatic push_frame(input logic [7:0] v);
        string hdr;
        string hx;
        hdr = "UART RX DATA: 0x";
        hx  = "0123456789ABCDEF";
        for (int i = 0; i < hdr.len(); i++) exp_q.push_back(hdr[i]);
        exp_q.push_back(hx[v[7:4]]);
        exp_q.push_back(hx[v[3:0]]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // driver: one 8N1 frame, stop level selectable
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            exp_rx_q.push_back(b);
            exp_valid++;
        end else begin
            exp_err++;
        end
        uart_rx = 1'b0;
        tick(BPS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(BPS);
        end
        uart_rx = stop_bit;
        tick(BPS);
        uart_rx = 1'b1;
        if (stop_bit) model_last = b;
    endtask

    task automatic send_glitch(input int len);
        uart_rx = 1'b0;
        tick(len);
        uart_rx = 1'b1;
        tick(20);
    endtask

    task automatic send_random(input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, ($urandom_range(0, 3) != 0));
            tick($urandom_range(0, 40));
        end
    endtask

    // monitor / scoreboard: rx pulses, tx busy windows, tx byte decoding
    always @(negedge clk) begin
        if (rst) begin
            mon_act   = 0;
            frame_pos = 0;
            exp_q.delete();
            busy_len  = 0;
            since_rst = 0;
        end else begin
            since_rst++;
            if (rx_valid === 1'b1) begin
                valid_cnt++;
                if (exp_rx_q.size() > 0) check("rx_valid_data", rx_data, exp_rx_q.pop_front());
                else check("rx_valid_unexpected", {24'h0, rx_data}, 32'h100);
            end
            if (rx_frame_err === 1'b1) err_cnt++;
            if (tx_busy === 1'b1) begin
                if (!busy_prev) check("busy_rise_start_bit", uart_tx, 0);
                busy_len++;
            end else if (busy_prev) begin
                check("busy_len", busy_len, 10 * BPS);
                busy_len = 0;
            end
            if (!mon_act) begin
                if (tx_prev && uart_tx === 1'b0) begin
                    mon_act = 1;
                    mon_cnt = 0;
                    if (frame_pos == 0) begin
                        frames_started++;
                        push_frame(model_last);
                        check("frame_start_time",
                              (since_rst >= PER) && (since_rst % PER >= 1) && (since_rst % PER <= 5), 1);
                    end
                end
            end else begin
                mon_cnt++;
                if (mon_cnt > BPS && mon_cnt < 9 * BPS && mon_cnt % BPS == BPS / 2) begin
                    mon_sh[mon_cnt / BPS - 1] = uart_tx;
                end else if (mon_cnt == 9 * BPS + BPS / 2) begin
                    check("tx_stop_bit", uart_tx, 1);
                    mon_act = 0;
                    if (exp_q.size() > 0) check("tx_byte", mon_sh, exp_q.pop_front());
                    else check("tx_byte_unexpected", {24'h0, mon_sh}, 32'h100);
                    frame_pos++;
                    if (frame_pos == 20) begin
                        frame_pos = 0;
                        frames_done++;
                    end
                end
            end
        end
        busy_prev = (tx_busy === 1'b1) && !rst;
        tx_prev   = (uart_tx !== 1'b0);
    end

    initial begin
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_led", led, 4'hF);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_frame_err", rx_frame_err, 0);
        tick(1);
        rst = 1'b0;
        tick(5);

        // good byte
        send_byte(8'hA5, 1'b1);
        check("a5_valid_cnt", valid_cnt, exp_valid);
        check("a5_err_cnt", err_cnt, 0);
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_led", led, 4'hA);

        // bad stop bit
        send_byte(8'h3C, 1'b0);
        tick(4);
        check("3c_err_cnt", err_cnt, 1);
        check("3c_valid_cnt", valid_cnt, exp_valid);
        check("3c_rx_data_kept", rx_data, 8'hA5);

        // start glitch, then back-to-back bytes
        send_glitch(2);
        check("glitch_valid_cnt", valid_cnt, exp_valid);
        check("glitch_err_cnt", err_cnt, exp_err);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("b2b_valid_cnt", valid_cnt, exp_valid);
        check("b2b_rx_data", rx_data, 8'hFF);
        check("b2b_led", led, 4'h0);

        // random traffic, then the byte the first report must show
        tick(10);
        send_random(3);
        check("rand1_valid_cnt", valid_cnt, exp_valid);
        check("rand1_err_cnt", err_cnt, exp_err);
        send_byte(8'h5A, 1'b1);
        check("5a_rx_data", rx_data, 8'h5A);

        for (int i = 0; i < 8000 && frames_done < 1; i++) @(posedge clk);
        #1;
        check("wait_frame1_done", frames_done >= 1, 1);

        // random traffic sets the second report's value
        send_random(4);
        check("rand2_valid_cnt", valid_cnt, exp_valid);
        exp_led = ~model_last[3:0];
        check("rand2_rx_data", rx_data, model_last);
        check("rand2_led", led, exp_led);

        for (int i = 0; i < 4000 && frames_started < 2; i++) @(posedge clk);
        #1;
        check("wait_frame2_start", frames_started >= 2, 1);
        tick(100);
        send_byte(8'h11, 1'b1);
        check("11_rx_data", rx_data, 8'h11);
        check("11_led", led, 4'hE);
        for (int i = 0; i < 3000 && frames_done < 2; i++) @(posedge clk);
        #1;
        check("wait_frame2_done", frames_done >= 2, 1);

        // third report carries 0x11; abort it during byte 7
        for (int i = 0; i < 6000 && !(frames_started >= 3 && frame_pos >= 7); i++) @(posedge clk);
        #1;
        check("wait_frame3_byte7", (frames_started >= 3) && (frame_pos >= 7), 1);
        tick(20);
        rst = 1'b1;
        exp_rx_q.delete();
        model_last = 8'h00;
        tick(1);
        @(negedge clk);
        check("midrst_uart_tx", uart_tx, 1);
        check("midrst_tx_busy", tx_busy, 0);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_led", led, 4'hF);
        tick(1);
        rst = 1'b0;

        for (int i = 0; i < 6000 && frames_done < 3; i++) @(posedge clk);
        #1;
        check("wait_frame4_done", frames_done >= 3, 1);
        tick(100);
        check("end_exp_q_empty", exp_q.size(), 0);
        check("end_exp_rx_q_empty", exp_rx_q.size(), 0);
        check("end_valid_cnt", valid_cnt, exp_valid);
        check("end_err_cnt", err_cnt, exp_err);
        check("end_frames_started", frames_started, 4);
        check("end_uart_tx_idle", uart_tx, 1);
        check("end_tx_busy", tx_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_frame_xcvr.md
Name: uart_frame_xcvr

Overview:
- Self-contained UART transceiver plus periodic report generator for board bring-up.
- Receives 8N1 bytes on uart_rx and shows the low nibble of the last byte on active-low LEDs.
- At a fixed interval, transmits a 20-byte ASCII report containing the last received byte in hex.
- Sits directly at the FPGA pins, between the board UART bridge and the LEDs.

Parameters:
- BPS_NUM, 434, clock cycles per UART bit (115200 baud at 50 MHz); must be ≥ 4.
- PERIOD_CYCLES, 50000000, clock cycles between report frame launches; must exceed 20*10*BPS_NUM.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial input, idle high.
- uart_tx  output  1  serial output, idle high.
- rx_data  output  8  last byte received with a valid stop bit.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_frame_err  output  1  one-cycle pulse when a received byte's stop bit samples low.
- tx_busy  output  1  high while the transmitter is shifting a byte.
- led  output  4  equals ~rx_data[3:0], combinational from rx_data.

Behaviour:
- Reset values:
  - uart_tx=1, rx_data=0x00, led=4'hF.
  - rx_valid=0, rx_frame_err=0, tx_busy=0.
  - Interval timer=0; generator idle; receiver idle.
- Receiver:
  - uart_rx passes through a 2-flop synchronizer.
  - Start is detected on a synchronized 1->0 transition while idle.
  - The line is re-sampled BPS_NUM/2 cycles (integer division) after detection. If it is high, the receiver treats the event as a glitch and returns to idle with no pulse.
  - 8 data bits are then sampled at BPS_NUM-cycle intervals, LSB first, followed by the stop bit one interval later.
  - Stop=1: rx_data is loaded and rx_valid pulses for 1 cycle, both in the cycle after the stop sample.
  - Stop=0: rx_data is unchanged and rx_frame_err pulses for 1 cycle instead.
  - The receiver returns to idle immediately after the stop sample. A new start edge is accepted from the next cycle, so back-to-back frames are supported.
  - States: IDLE, START, DATA, STOP.
- Transmitter (internal request interface tx_start/tx_byte, driven by the generator only):
  - A request is accepted only when tx_busy=0. tx_busy rises in the same cycle uart_tx drives the start bit (the cycle after acceptance).
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BPS_NUM cycles.
  - tx_busy falls after the stop bit completes, so one byte occupies 10*BPS_NUM cycles of busy.
  - States: IDLE, START, DATA, STOP.
- Generator:
  - A free-running timer counts 0..PERIOD_CYCLES-1 and wraps; launch occurs at wrap.
  - At launch, rx_data is snapshotted into a report byte and a 20-byte frame starts.
  - Frame content, index 0..19: ASCII "UART RX DATA: 0x", then uppercase hex of the high nibble, uppercase hex of the low nibble, 0x0D, 0x0A.
  - Bytes are issued strictly in order, each as soon as tx_busy=0 and the previous request has been accepted. The generator never issues two requests within one byte time; after a request it waits for tx_busy to rise and fall.
  - A wrap during an active frame is ignored; no queuing and no restart.
  - Bytes received mid-frame do not alter the snapshot.
- rst asserted mid-operation aborts RX and TX and clears the generator. uart_tx returns to 1 on the next edge.

Test Plan:
- Reset with BPS_NUM=8, PERIOD_CYCLES=4000: assert rst for 3 cycles -> uart_tx=1, rx_data=0x00, led=4'hF, tx_busy=0, no pulses.
- RX byte 0xA5 with valid stop -> single rx_valid pulse; rx_data=0xA5; led=4'hA; rx_frame_err stays 0.
- RX byte 0x3C with stop bit driven 0 -> rx_frame_err pulses once; rx_data remains at its prior value; no rx_valid.
- RX start glitch of 2 cycles low -> no pulse; then back-to-back bytes 0x01, 0xFF -> two rx_valid pulses with rx_data 0x01 then 0xFF; led=4'h0 at the end.
- After receiving 0x5A, wait for launch -> decoded uart_tx stream is exactly "UART RX DATA: 0x5A\r\n" (20 bytes). Each bit is 8 cycles wide; tx_busy is high for 80 cycles per byte.
- Send 0x11 over RX mid-frame, and assert rst during byte 7 of a frame -> the in-progress frame keeps the old hex digits; after reset, uart_tx=1 and the next frame starts at "U" at the next timer wrap.
